// File: rtl/lane_spawn_queue.sv
// Lane spawner: samples the 2-bit random stream every INTERVAL game ticks,
// optionally bumps repeated lanes, and queues them in a small registered-head FIFO.
module lane_spawn_queue #(
  parameter int INTERVAL  = 8,
  parameter int DEPTH     = 4,
  parameter int NO_REPEAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     tick,
  input  logic [1:0]               ran_in,
  input  logic                     pop,
  output logic                     spawn_valid,
  output logic [1:0]               spawn_lane,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic [1:0]      head_q, head_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      last_q, last_d;

  logic            push_req_s;
  logic            push_eff_s;
  logic            pop_eff_s;
  logic            full_s;
  logic [1:0]      lane_s;

  // Next-state logic: run/idle FSM, tick divider, lane select and FIFO update.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    push_req_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tcnt_d = {TW{1'b0}};
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          tcnt_d  = {TW{1'b0}};
        end else if (tick) begin
          if (tcnt_q == TW'(INTERVAL - 1)) begin
            tcnt_d     = {TW{1'b0}};
            push_req_s = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = {TW{1'b0}};
      end
    endcase

    if ((NO_REPEAT != 0) && (ran_in == last_q)) begin
      lane_s = ran_in + 2'd1;
    end else begin
      lane_s = ran_in;
    end

    full_s     = (count_q == CW'(DEPTH));
    pop_eff_s  = pop && (count_q != {CW{1'b0}});
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_eff_s = push_req_s && (!full_s || pop_eff_s);

    if (push_eff_s) begin
      mem_d[wr_ptr_q] = lane_s;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      last_d          = lane_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (push_req_s && !push_eff_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (pop_eff_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_eff_s, pop_eff_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != {CW{1'b0}});
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d];
    end else begin
      head_d = 2'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= {TW{1'b0}};
      mem_q    <= '{default: 2'b00};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      valid_q  <= 1'b0;
      head_q   <= 2'd0;
      ovf_q    <= 1'b0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_lane  = head_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule
